// File: rtl/clz_seq_ctrl.sv
// clz_seq_ctrl -- multi-cycle count-leading-zeros / count-leading-ones
// sequencer for the execute stage (MIPS CLZ / CLO).
//
// The operand is scanned CHUNK bits per cycle, starting at the MSB, instead
// of going through a single 32-deep priority chain. A start/busy/done
// handshake lets pipeline control stall ID/EX while a count is in flight.
//
// Parameters:
//   CHUNK   bits examined per SCAN cycle (1, 2, 4, 8, 16 or 32).
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous reset, active-low
//   start    in   request a count (honoured only in IDLE or DONE)
//   op       in   0 = CLZ, 1 = CLO (sampled with start)
//   datain   in   32-bit operand (sampled with start)
//   flush    in   synchronous abort from pipeline control, beats start
//   busy     out  high while scanning
//   done     out  one-cycle pulse when dataout has just been updated
//   dataout  out  count 0..32, zero-extended, held until the next result
module clz_seq_ctrl #(
  parameter int CHUNK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] datain,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] dataout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] CHUNK_W = 6'(CHUNK);

  state_t      state;
  logic [31:0] sh;        // operand, CLO inverted so both ops count zeros
  logic [5:0]  cnt;       // zeros already skipped in whole chunks

  logic [CHUNK-1:0] top;
  logic [5:0]       top_lz;
  logic             top_seen;
  logic [31:0]      start_sh;

  // Leading-zero count inside the current top chunk. Only used when the
  // chunk is non-zero, so the result is always 0..CHUNK-1.
  // NOTE: every variable assigned here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    top      = sh[31 -: CHUNK];
    top_lz   = 6'd0;
    top_seen = 1'b0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (!top_seen) begin
        if (top[i]) top_seen = 1'b1;
        else        top_lz   = top_lz + 6'd1;
      end
    end
  end

  assign start_sh = op ? ~datain : datain;

  // Single registered FSM; busy and done are registered alongside the state
  // so they are glitch-free for the stall logic.
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      dataout <= 32'd0;
      sh      <= 32'd0;
      cnt     <= 6'd0;
    end else if (flush) begin
      // Abort: drop any in-flight count, keep the last published result.
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            sh  <= start_sh;
            cnt <= 6'd0;
            if (start_sh == 32'd0) begin
              // All 32 bits match: answer is known without scanning.
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              dataout <= 32'd32;
            end else begin
              state <= SCAN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end

        SCAN: begin
          // sh was non-zero on entry, so a non-zero chunk is always found
          // before cnt can reach 32.
          if (top != '0) begin
            dataout <= {26'd0, cnt + top_lz};
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            cnt <= cnt + CHUNK_W;
            sh  <= sh << CHUNK;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clz_seq_ctrl.sv
// Self-checking bench for clz_seq_ctrl. Expected results and their due
// cycles come from a behavioural bit-by-bit model and are queued when a
// start is driven; a monitor pops and compares on every done pulse.
module tb_clz_seq_ctrl;

  localparam int CHUNK = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] datain;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] dataout;

  clz_seq_ctrl #(.CHUNK(CHUNK)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .datain  (datain),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .dataout (dataout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;     // number of rising edges seen so far
  logic [31:0] last_res = 32'd0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural reference: plain MSB-first bit count, then the chunk index
  // in which the first significant bit sits gives the scan length.
  function automatic void model(input logic o, input logic [31:0] d,
                                output logic [31:0] res, output int k);
    logic [31:0] s;
    int          lz;
    bit          seen;
    s    = o ? ~d : d;
    lz   = 0;
    seen = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!seen) begin
        if (s[i]) seen = 1'b1;
        else      lz++;
      end
    end
    if (lz == 32) begin
      res = 32'd32;
      k   = 0;
    end else begin
      res = 32'(lz);
      k   = lz / CHUNK + 1;
    end
  endfunction

  // Monitor: sample just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) begin
        if (sb.size() == 0) begin
          check("spurious_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.tag, "_result"}, dataout, e.res);
          check({e.tag, "_latency"}, 32'(cyc), 32'(e.due));
          last_res = e.res;
        end
      end
    end
  end

  // Drive a start for one cycle (released by the caller). The request is
  // sampled at edge e; the result is due k edges later.
  task automatic issue(input logic o, input logic [31:0] d, input string tag,
                       input bit push, output int e, output int k);
    logic [31:0] res;
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    datain = d;
    model(o, d, res, k);
    e = cyc + 1;
    if (push) sb.push_back('{tag, res, e + k});
  endtask

  // Release start, then wait for the scoreboard to empty while checking that
  // busy covers exactly the scan cycles (after edges e .. e+k-1).
  task automatic drain(input string tag, input int e, input int k);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy"}, 32'(busy), 32'((cyc >= e) && (cyc < e + k)));
      if (sb.size() == 0) return;
    end
    check({tag, "_timeout_pending"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic run_op(input logic o, input logic [31:0] d, input string tag);
    int e, k;
    issue(o, d, tag, 1'b1, e, k);
    drain(tag, e, k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, k, e2, k2;
    logic [31:0] r2;

    rst_n  = 1'b0;
    start  = 1'b1;
    op     = 1'b0;
    datain = 32'd0;
    flush  = 1'b0;

    // Reset held with start asserted: nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_dataout", dataout, 32'd0);
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Directed cases.
    run_op(1'b0, 32'h8000_0000, "clz_msb");
    run_op(1'b0, 32'h0000_0001, "clz_lsb");
    run_op(1'b1, 32'hFFFF_0000, "clo_half");
    run_op(1'b0, 32'h0000_0000, "clz_zero");
    run_op(1'b1, 32'hFFFF_FFFF, "clo_ones");
    run_op(1'b0, 32'h0800_0000, "clz_4");
    run_op(1'b1, 32'h7FFF_FFFF, "clo_0");

    // Random operands with a random number of leading bits cleared.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] d;
      d = $urandom >> $urandom_range(0, 31);
      run_op(1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? d : ~d,
             "rand");
    end

    // Back-to-back: new start during the DONE cycle of the previous op.
    issue(1'b0, 32'h8000_0000, "b2b_a", 1'b1, e, k);
    @(negedge clk);
    start = 1'b0;
    while (cyc < e + k) @(negedge clk);
    check("b2b_done_cycle", 32'(done), 32'd1);
    start  = 1'b1;
    op     = 1'b0;
    datain = 32'h00F0_0000;
    model(1'b0, 32'h00F0_0000, r2, k2);
    e2 = cyc + 1;
    sb.push_back('{"b2b_b", r2, e2 + k2});
    drain("b2b_b", e2, k2);

    // Start while scanning is ignored; original result stands.
    issue(1'b0, 32'h0000_0001, "scan_start", 1'b1, e, k);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start  = 1'b1;
    datain = 32'h8000_0000;
    drain("scan_start", e, k);

    // Flush mid-scan: no done, dataout keeps the last result.
    issue(1'b0, 32'h0000_0001, "flush", 1'b0, e, k);
    @(negedge clk);
    start = 1'b0;
    while (cyc < e + 3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    repeat (12) @(negedge clk);
    check("flush_dataout_held", dataout, last_res);

    // Start and flush together: flush wins, fast-path operand not taken.
    @(negedge clk);
    start  = 1'b1;
    flush  = 1'b1;
    op     = 1'b0;
    datain = 32'd0;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("sf_busy", 32'(busy), 32'd0);
    check("sf_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("sf_dataout_held", dataout, last_res);

    // Reset during scan: operation lost, outputs back to reset values.
    issue(1'b0, 32'h0000_0001, "rst_scan", 1'b0, e, k);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_scan_busy", 32'(busy), 32'd0);
    check("rst_scan_dataout", dataout, 32'd0);
    last_res = 32'd0;
    repeat (12) @(negedge clk);

    // One more op after the aborts to show the block recovered.
    run_op(1'b1, 32'hFFF0_0000, "post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clz_seq_ctrl.md
Name: clz_seq_ctrl

Overview:
- Multi-cycle sequencer for the count-leading-zeros/ones operation (MIPS CLZ/CLO) in the CPU54 execute stage.
- Replaces the 32-deep priority chain with an iterative scan of CHUNK bits per cycle. This shortens the critical path.
- Uses a start/busy/done handshake so the pipeline control can stall the ID/EX stages while a count is in flight.
- Sits beside the ALU and is driven by the decode signals for CLZ/CLO.

Parameters:
- CHUNK, 4, bits examined per SCAN cycle. Legal values are 1, 2, 4, 8, 16 and 32, and the value must divide 32.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  request a count. Sampled only in IDLE or DONE.
- op  input  1  operation select: 0 = CLZ, 1 = CLO. Sampled with start.
- datain  input  32  operand (rs). Sampled with start.
- flush  input  1  synchronous abort from pipeline control (branch/exception flush).
- busy  output  1  high while in SCAN. Pipeline control ORs it into the stall signal.
- done  output  1  one-cycle pulse when result becomes valid.
- dataout  output  32  count, range 0..32, zero-extended. Held until the next completed operation.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-low, sampled on the rising edge of clk. No asynchronous paths.
- Reset values: state = IDLE, busy = 0, done = 0, dataout = 0, internal shift register = 0, count = 0.
- States:
  - IDLE: waiting for start.
  - SCAN: iterating over the operand.
  - DONE: result valid. Lasts exactly 1 cycle.
- Accepting start (in IDLE or DONE, start = 1, flush = 0):
  - Latch sh = (op ? ~datain : datain) and set cnt = 0.
  - If sh == 0, this is the fast path: next state DONE and dataout = 32 at that edge. Latency is 1 cycle and busy is never asserted.
  - Otherwise, next state SCAN.
- SCAN, on each cycle:
  - Let top = sh[31 -: CHUNK].
  - If top != 0: dataout = cnt + leading-zero count of top (0..CHUNK-1), then go to DONE.
  - Else: cnt += CHUNK, sh <<= CHUNK, stay in SCAN.
  - Because sh != 0 on entry, SCAN always terminates within 32/CHUNK cycles. cnt never reaches 32 inside SCAN.
- Latency: with start accepted at edge T, done is high in cycle T+k+1, where k = index (1-based) of the first non-zero chunk from the MSB. Worst case is 32/CHUNK + 1 cycles. With CHUNK = 4 that is 9.
- DONE:
  - done = 1 for that cycle only.
  - If start = 1 in the same cycle, the new operation is accepted (back-to-back), using the same rules as IDLE.
  - Otherwise, go to IDLE.
- start while in SCAN is ignored. There is no queueing; the requester must hold off while busy = 1.
- dataout is written only on the transition into DONE. It is never observable mid-scan.
- flush = 1, in any state:
  - Next state IDLE, done = 0 next cycle.
  - dataout, sh and cnt are not updated.
  - flush has priority over start in the same cycle.
- rst_n = 0 mid-SCAN: same as the reset values above, the operation is lost and done is not emitted.
- Arithmetic: cnt is 6 bits. dataout[31:6] = 0.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with start = 1 -> busy = 0, done = 0, dataout = 0x00000000. No start accepted until rst_n = 1.
- CLZ 0x80000000, CHUNK = 4, start at T -> busy high in T+1, done pulse at T+2, dataout = 0.
- CLZ 0x00000001 -> busy high T+1..T+8, done at T+9, dataout = 31. CLO 0xFFFF0000 -> done at T+6, dataout = 16.
- Fast path: CLZ 0x00000000 -> done at T+1, dataout = 32, busy never high. CLO 0xFFFFFFFF -> done at T+1, dataout = 32.
- Back-to-back: start = 1 during the DONE cycle with CLZ 0x00F00000 -> second done 3 cycles later with dataout = 8. Also assert start mid-SCAN -> ignored, result unchanged.
- Flush: CLZ 0x00000001, flush at T+4 -> IDLE at T+5, no done pulse, dataout keeps its previous value. Also assert start and flush together -> no operation accepted.
